// File: rtl/pacman_input.sv
// NES controller front end for Pac-Man: per-button debounce, Start/A press pulses,
// pause toggle and a pending-direction handshake with the game tick.
module pacman_input #(
   parameter int unsigned DEBOUNCE_FRAMES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] buttons,
   input  logic       buttons_valid,
   input  logic       game_tick,
   output logic [7:0] held,
   output logic [1:0] dir_req,
   output logic       dir_valid,
   output logic       start_pulse,
   output logic       a_pulse,
   output logic       paused
);

   typedef enum logic [1:0] {
      DIR_NONE    = 2'd0,
      DIR_PENDING = 2'd1,
      DIR_LATCHED = 2'd2
   } dir_state_e;

   localparam logic [3:0] DB_LIMIT = 4'(DEBOUNCE_FRAMES);

   localparam int unsigned BIT_A     = 7;
   localparam int unsigned BIT_START = 4;
   localparam int unsigned BIT_UP    = 3;
   localparam int unsigned BIT_DOWN  = 2;
   localparam int unsigned BIT_LEFT  = 1;
   localparam int unsigned BIT_RIGHT = 0;

   logic [3:0] cnt_q [8];
   logic [3:0] cnt_d [8];
   logic [7:0] held_q, held_d;
   logic       start_pulse_q, start_pulse_d;
   logic       a_pulse_q, a_pulse_d;
   logic       paused_q, paused_d;
   logic [1:0] dir_req_q, dir_req_d;
   dir_state_e state_q, state_d;

   logic [7:0] press;
   logic [1:0] dir_sel;
   logic       dir_hit;

   // Debounce: a differing bit must persist for DB_LIMIT valid frames to flip.
   always_comb begin
      // NOTE: every comb output gets a default first so no path can infer a latch.
      held_d = held_q;
      for (int i = 0; i < 8; i++) begin
         cnt_d[i] = cnt_q[i];
         if (buttons_valid) begin
            if (buttons[i] == held_q[i]) begin
               cnt_d[i] = 4'd0;
            end else if (cnt_q[i] + 4'd1 == DB_LIMIT) begin
               held_d[i] = ~held_q[i];
               cnt_d[i]  = 4'd0;
            end else begin
               cnt_d[i] = cnt_q[i] + 4'd1;
            end
         end
      end
   end

   assign press = held_d & ~held_q;

   always_comb begin
      start_pulse_d = press[BIT_START];
      a_pulse_d     = press[BIT_A];
      paused_d      = paused_q ^ press[BIT_START];
   end

   // Highest-priority new direction; ignored while already paused.
   always_comb begin
      dir_sel = 2'b11;
      if (press[BIT_UP])         dir_sel = 2'b00;
      else if (press[BIT_DOWN])  dir_sel = 2'b01;
      else if (press[BIT_LEFT])  dir_sel = 2'b10;
      else if (press[BIT_RIGHT]) dir_sel = 2'b11;
      dir_hit = (|press[BIT_UP:BIT_RIGHT]) && !paused_q;
   end

   always_comb begin
      state_d   = state_q;
      dir_req_d = dir_req_q;
      if (dir_hit) begin
         state_d   = DIR_PENDING;
         dir_req_d = dir_sel;
      end else if (game_tick && state_q == DIR_PENDING) begin
         state_d = DIR_LATCHED;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the counter array is small control state, so it is reset like any flop;
         // leaving it unreset would let stale progress survive a reset.
         for (int i = 0; i < 8; i++) cnt_q[i] <= 4'd0;
         held_q        <= 8'h00;
         start_pulse_q <= 1'b0;
         a_pulse_q     <= 1'b0;
         paused_q      <= 1'b0;
         dir_req_q     <= 2'b00;
         state_q       <= DIR_NONE;
      end else begin
         // NOTE: non-blocking so every flop samples the pre-edge values of the others.
         for (int i = 0; i < 8; i++) cnt_q[i] <= cnt_d[i];
         held_q        <= held_d;
         start_pulse_q <= start_pulse_d;
         a_pulse_q     <= a_pulse_d;
         paused_q      <= paused_d;
         dir_req_q     <= dir_req_d;
         state_q       <= state_d;
      end
   end

   assign held        = held_q;
   assign dir_req     = dir_req_q;
   assign dir_valid   = (state_q == DIR_PENDING);
   assign start_pulse = start_pulse_q;
   assign a_pulse     = a_pulse_q;
   assign paused      = paused_q;

endmodule

// File: tb/tb_pacman_input.sv
// Directed bench for pacman_input at DEBOUNCE_FRAMES=2; each task checks one scenario.
module tb_pacman_input;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] buttons = 8'h00;
   logic       buttons_valid = 1'b0;
   logic       game_tick = 1'b0;
   logic [7:0] held;
   logic [1:0] dir_req;
   logic       dir_valid;
   logic       start_pulse;
   logic       a_pulse;
   logic       paused;

   int checks = 0;
   int errors = 0;

   // {held, dir_req, dir_valid, start_pulse, a_pulse, paused}
   logic [13:0] obs;
   assign obs = {held, dir_req, dir_valid, start_pulse, a_pulse, paused};

   pacman_input #(.DEBOUNCE_FRAMES(2)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .buttons      (buttons),
      .buttons_valid(buttons_valid),
      .game_tick    (game_tick),
      .held         (held),
      .dir_req      (dir_req),
      .dir_valid    (dir_valid),
      .start_pulse  (start_pulse),
      .a_pulse      (a_pulse),
      .paused       (paused)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish in time");
      $fatal(1);
   end

   // Presents one frame; returns #1 after the edge that sampled it.
   task automatic send_frame(input logic [7:0] b, input logic tick);
      @(posedge clk);
      #1;
      buttons       = b;
      buttons_valid = 1'b1;
      game_tick     = tick;
      @(posedge clk);
      #1;
      buttons_valid = 1'b0;
      game_tick     = 1'b0;
   endtask

   task automatic idle_cycle(input logic tick);
      @(posedge clk);
      #1;
      game_tick = tick;
      @(posedge clk);
      #1;
      game_tick = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      buttons = 8'h00;
      buttons_valid = 1'b0;
      game_tick = 1'b0;
      #20;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      buttons = 8'hFF;
      buttons_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (obs !== 14'h0000) begin
         errors++;
         $display("FAIL reset_state: got %h expected %h", obs, 14'h0000);
      end
      buttons_valid = 1'b0;
      buttons = 8'h00;
      rst_n = 1'b1;
   endtask

   task automatic test_press_up();
      do_reset();
      send_frame(8'h08, 1'b0);
      checks++;
      if (obs !== {8'h00, 2'b00, 1'b0, 3'b000}) begin
         errors++;
         $display("FAIL up_first_frame: got %h expected %h", obs, {8'h00, 2'b00, 1'b0, 3'b000});
      end
      send_frame(8'h08, 1'b0);
      checks++;
      if (obs !== {8'h08, 2'b00, 1'b1, 3'b000}) begin
         errors++;
         $display("FAIL up_second_frame: got %h expected %h", obs, {8'h08, 2'b00, 1'b1, 3'b000});
      end
   endtask

   task automatic test_glitch();
      do_reset();
      send_frame(8'h02, 1'b0);
      send_frame(8'h00, 1'b0);
      send_frame(8'h02, 1'b0);
      checks++;
      if (obs !== 14'h0000) begin
         errors++;
         $display("FAIL glitch: got %h expected %h", obs, 14'h0000);
      end
      // Strobe-less cycles must not advance the counter.
      @(posedge clk);
      #1;
      buttons = 8'h02;
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if (obs !== 14'h0000) begin
         errors++;
         $display("FAIL hold_without_valid: got %h expected %h", obs, 14'h0000);
      end
   endtask

   task automatic test_tick_then_down();
      do_reset();
      send_frame(8'h08, 1'b0);
      send_frame(8'h08, 1'b0);
      idle_cycle(1'b1);
      checks++;
      if (obs !== {8'h08, 2'b00, 1'b0, 3'b000}) begin
         errors++;
         $display("FAIL tick_latches: got %h expected %h", obs, {8'h08, 2'b00, 1'b0, 3'b000});
      end
      idle_cycle(1'b1);
      checks++;
      if (obs !== {8'h08, 2'b00, 1'b0, 3'b000}) begin
         errors++;
         $display("FAIL tick_in_latched: got %h expected %h", obs, {8'h08, 2'b00, 1'b0, 3'b000});
      end
      send_frame(8'h0C, 1'b0);
      send_frame(8'h0C, 1'b0);
      checks++;
      if (obs !== {8'h0C, 2'b01, 1'b1, 3'b000}) begin
         errors++;
         $display("FAIL down_pending: got %h expected %h", obs, {8'h0C, 2'b01, 1'b1, 3'b000});
      end
      // Releasing both keeps heading and pending state.
      send_frame(8'h00, 1'b0);
      send_frame(8'h00, 1'b0);
      checks++;
      if (obs !== {8'h00, 2'b01, 1'b1, 3'b000}) begin
         errors++;
         $display("FAIL release_keeps_dir: got %h expected %h", obs, {8'h00, 2'b01, 1'b1, 3'b000});
      end
   endtask

   task automatic test_pause();
      do_reset();
      send_frame(8'h10, 1'b0);
      send_frame(8'h10, 1'b0);
      checks++;
      if (obs !== {8'h10, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL start_pulse: got %h expected %h", obs, {8'h10, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1});
      end
      @(posedge clk);
      #1;
      checks++;
      if (obs !== {8'h10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL start_pulse_width: got %h expected %h", obs, {8'h10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1});
      end
      send_frame(8'h11, 1'b0);
      send_frame(8'h11, 1'b0);
      checks++;
      if (obs !== {8'h11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL paused_ignores_right: got %h expected %h", obs, {8'h11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1});
      end
      send_frame(8'h00, 1'b0);
      send_frame(8'h00, 1'b0);
      checks++;
      if (obs !== {8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL start_release: got %h expected %h", obs, {8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1});
      end
      send_frame(8'h10, 1'b0);
      send_frame(8'h10, 1'b0);
      checks++;
      if (obs !== {8'h10, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL unpause: got %h expected %h", obs, {8'h10, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0});
      end
   endtask

   task automatic test_tick_collision();
      do_reset();
      send_frame(8'h08, 1'b0);
      send_frame(8'h08, 1'b0);
      send_frame(8'h0A, 1'b0);
      send_frame(8'h0A, 1'b1);
      checks++;
      if (obs !== {8'h0A, 2'b10, 1'b1, 3'b000}) begin
         errors++;
         $display("FAIL tick_vs_left: got %h expected %h", obs, {8'h0A, 2'b10, 1'b1, 3'b000});
      end
   endtask

   task automatic test_priority_and_a();
      do_reset();
      send_frame(8'h0F, 1'b0);
      send_frame(8'h0F, 1'b0);
      checks++;
      if (obs !== {8'h0F, 2'b00, 1'b1, 3'b000}) begin
         errors++;
         $display("FAIL priority_up: got %h expected %h", obs, {8'h0F, 2'b00, 1'b1, 3'b000});
      end
      do_reset();
      send_frame(8'h83, 1'b0);
      send_frame(8'h83, 1'b0);
      checks++;
      if (obs !== {8'h83, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL priority_left_a: got %h expected %h", obs, {8'h83, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0});
      end
      @(posedge clk);
      #1;
      checks++;
      if (obs !== {8'h83, 2'b10, 1'b1, 3'b000}) begin
         errors++;
         $display("FAIL a_pulse_width: got %h expected %h", obs, {8'h83, 2'b10, 1'b1, 3'b000});
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      send_frame(8'hFF, 1'b0);
      send_frame(8'hFF, 1'b0);
      checks++;
      if (obs !== {8'hFF, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL all_pressed: got %h expected %h", obs, {8'hFF, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1});
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (obs !== 14'h0000) begin
         errors++;
         $display("FAIL async_reset: got %h expected %h", obs, 14'h0000);
      end
      #10;
      rst_n = 1'b1;
      // Progress made before a reset is discarded.
      send_frame(8'h08, 1'b0);
      do_reset();
      send_frame(8'h08, 1'b0);
      checks++;
      if (obs !== 14'h0000) begin
         errors++;
         $display("FAIL reset_discards_count: got %h expected %h", obs, 14'h0000);
      end
      send_frame(8'h08, 1'b0);
      checks++;
      if (obs !== {8'h08, 2'b00, 1'b1, 3'b000}) begin
         errors++;
         $display("FAIL count_after_reset: got %h expected %h", obs, {8'h08, 2'b00, 1'b1, 3'b000});
      end
   endtask

   initial begin
      test_reset();
      test_press_up();
      test_glitch();
      test_tick_then_down();
      test_pause();
      test_tick_collision();
      test_priority_and_a();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pacman_input.md
PACMAN_INPUT -- requirements
Module: pacman_input

Interface
REQ-001 Parameter DEBOUNCE_FRAMES, default 2, consecutive identical input frames needed to change a button's debounced state (legal 1..15).
REQ-002 clk  input  1  system clock; all logic rising-edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 buttons  input  8  raw NES frame, 1 = pressed; bit7 A, 6 B, 5 Select, 4 Start, 3 Up, 2 Down, 1 Left, 0 Right; already in clk domain.
REQ-005 buttons_valid  input  1  one-cycle strobe: buttons holds a complete new frame.
REQ-006 game_tick  input  1  one-cycle strobe: game logic consumes the pending direction request.
REQ-007 held  output  8  debounced button state, same bit order as buttons.
REQ-008 dir_req  output  2  requested direction: 00 Up, 01 Down, 10 Left, 11 Right.
REQ-009 dir_valid  output  1  a direction request is pending and not yet consumed.
REQ-010 start_pulse  output  1  one-cycle pulse on debounced Start press.
REQ-011 a_pulse  output  1  one-cycle pulse on debounced A press.
REQ-012 paused  output  1  pause state, toggled by Start.

Function
REQ-013 Per-button 4-bit agreement counter; evaluated only on cycles with buttons_valid=1; all other cycles hold state.
REQ-014 On a valid frame where buttons[i] equals held[i], counter i clears to 0.
REQ-015 On a valid frame where buttons[i] differs from held[i], counter i increments; when the incremented value reaches DEBOUNCE_FRAMES, held[i] flips and the counter clears.
REQ-016 held updates on the clock edge that samples buttons_valid (registered, one cycle after the strobe is presented).
REQ-017 Press edge of bit i: held[i] goes 0->1 in that update; release edges produce no pulses.
REQ-018 start_pulse and a_pulse assert for exactly the one cycle following the update that produced the respective press edge.
REQ-019 paused toggles on the same edge that asserts start_pulse.
REQ-020 Direction FSM states: NONE (no direction ever accepted), PENDING (dir_valid=1), LATCHED (dir_valid=0, dir_req holds last direction).
REQ-021 A direction press edge (bits 3..0) while paused=0 loads dir_req and enters PENDING from any state.
REQ-022 Multiple direction press edges in one update: priority Up > Down > Left > Right.
REQ-023 Direction press edges while paused=1 are ignored; FSM and dir_req hold.
REQ-024 game_tick in PENDING -> LATCHED; game_tick in NONE or LATCHED has no effect.
REQ-025 game_tick and a new direction press edge in the same cycle: new request wins; state PENDING with new dir_req.
REQ-026 Releasing a direction does not change dir_req or state (Pac-Man keeps last heading).
REQ-027 Pause entry (paused 0->1) while PENDING leaves PENDING; game_tick is still honoured.
REQ-028 Counters saturate-free by construction: counter never exceeds DEBOUNCE_FRAMES-1 between evaluations.

Reset
REQ-029 rst_n low asynchronously forces: held=0, all counters=0, dir_req=00, dir_valid=0, FSM=NONE, start_pulse=0, a_pulse=0, paused=0.
REQ-030 Reset asserted mid-debounce or mid-PENDING discards all progress; first valid frame after release starts counting from 0.
REQ-031 Inputs ignored while rst_n low; normal operation on first rising edge after rst_n high.

Verification
REQ-032 DEBOUNCE_FRAMES=2; two valid frames buttons=0x08 -> held=0x08, dir_req=00, dir_valid=1 one cycle after second strobe.
REQ-033 Glitch: frames 0x02, 0x00, 0x02 -> held stays 0x00, dir_valid stays 0, no pulses.
REQ-034 PENDING Up, then game_tick -> dir_valid=0, dir_req=00; later frames 0x0C twice (Up held, Down new) -> dir_req=01, dir_valid=1.
REQ-035 Start pressed two frames -> start_pulse high exactly one cycle, paused=1; Right pressed two frames -> dir unchanged; release and re-press Start -> paused=0.
REQ-036 game_tick coincident with new Left press edge -> dir_req=10, dir_valid=1 after that edge.
REQ-037 rst_n pulsed low with held=0xFF and dir_valid=1 -> all outputs 0 immediately (no clock edge), FSM=NONE.
